// File: rtl/prog_uart_loader_pkg.sv
// Shared definitions for the UART program loader.
//   SYNC_BYTE   : frame start marker
//   ADDR_W/DATA_W : memory write port widths
//   frameState_t  : frame FSM encoding
//   rxState_t     : serial receiver FSM encoding
package prog_uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA_LO,
    DATA_HI,
    CHECK
  } frameState_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

endpackage

// File: rtl/prog_uart_loader_if.sv
// Memory write port bundle driven by the loader.
//   addrWr   : write address
//   dataWr   : write data {high byte, low byte}
//   wrEn     : one-cycle write strobe
//   loadDone : image accepted with good checksum (level)
//   loadErr  : one-cycle framing/checksum error pulse
// master = loader side, slave = memory/observer side.
interface prog_uart_loader_if;
  import prog_uart_loader_pkg::*;

  logic [ADDR_W-1:0] addrWr;
  logic [DATA_W-1:0] dataWr;
  logic              wrEn;
  logic              loadDone;
  logic              loadErr;

  modport master (
    output addrWr, dataWr, wrEn, loadDone, loadErr
  );

  modport slave (
    input addrWr, dataWr, wrEn, loadDone, loadErr
  );

endinterface

// File: rtl/prog_uart_loader_uart_rx.sv
// 8N1 serial receiver, LSB first, BIT_CYC = CLK_FREQ/BAUD clocks per bit.
//   clk, rst  : system clock, async active-high reset
//   rx        : raw serial line (idle high), synchronized internally
//   rxByte    : received byte, valid while byteValid is high
//   byteValid : one-cycle pulse in the stop-bit sample cycle (good stop)
//   frameErr  : one-cycle pulse in the stop-bit sample cycle (stop low)
module uart_rx #(
  parameter int unsigned CLK_FREQ = 1000,
  parameter int unsigned BAUD     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       frameErr
);
  import prog_uart_loader_pkg::*;

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
  localparam int unsigned HALF    = BIT_CYC / 2;
  localparam int unsigned CW      = $clog2(BIT_CYC + 1);

  logic          rxMeta, rxSync, rxPrev;
  rxState_t      state, stateN;
  logic [CW-1:0] cnt, cntN;
  logic [2:0]    bitIdx, bitIdxN;
  logic [7:0]    shReg, shRegN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
      state  <= RX_IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shReg  <= '0;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      state  <= stateN;
      cnt    <= cntN;
      bitIdx <= bitIdxN;
      shReg  <= shRegN;
    end
  end

  always_comb begin
    stateN    = state;
    cntN      = cnt;
    bitIdxN   = bitIdx;
    shRegN    = shReg;
    byteValid = 1'b0;
    frameErr  = 1'b0;
    case (state)
      RX_IDLE: begin
        // falling edge of the synchronized line
        if (rxPrev && !rxSync) begin
          stateN = RX_START;
          cntN   = '0;
        end
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cntN    = '0;
          bitIdxN = '0;
          // still low at mid-start: real start bit, else a glitch
          stateN  = rxSync ? RX_IDLE : RX_DATA;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(BIT_CYC - 1)) begin
          cntN    = '0;
          shRegN  = {rxSync, shReg[7:1]};
          bitIdxN = bitIdx + 1'b1;
          if (bitIdx == 3'd7) stateN = RX_STOP;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CW'(BIT_CYC - 1)) begin
          cntN      = '0;
          stateN    = RX_IDLE;
          byteValid = rxSync;
          frameErr  = !rxSync;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      default: stateN = RX_IDLE;
    endcase
  end

  assign rxByte = shReg;

endmodule

// File: rtl/prog_uart_loader.sv
// UART program loader: receives A5, N, 2N data bytes, checksum, and writes
// N 16-bit words to a 1R1W memory starting at address 0.
//   clk, rst : system clock, async active-high reset
//   rx       : serial input, 8N1, idle high
//   memWr    : memory write port (addrWr, dataWr, wrEn, loadDone, loadErr)
module prog_uart_loader #(
  parameter int unsigned CLK_FREQ = 1000,
  parameter int unsigned BAUD     = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  prog_uart_loader_if.master  memWr
);
  import prog_uart_loader_pkg::*;

  logic [7:0] rxByte;
  logic       byteValid, frameErr;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) uRx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxByte    (rxByte),
    .byteValid (byteValid),
    .frameErr  (frameErr)
  );

  frameState_t       state, stateN;
  logic [7:0]        count, countN;
  logic [ADDR_W-1:0] addr, addrN;
  logic [7:0]        lowByte, lowByteN;
  logic [7:0]        csum, csumN;
  logic [ADDR_W-1:0] addrWr, addrWrN;
  logic [DATA_W-1:0] dataWr, dataWrN;
  logic              wrEn, wrEnN;
  logic              loadDone, loadDoneN;
  logic              loadErr, loadErrN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      addr     <= '0;
      lowByte  <= '0;
      csum     <= '0;
      addrWr   <= '0;
      dataWr   <= '0;
      wrEn     <= 1'b0;
      loadDone <= 1'b0;
      loadErr  <= 1'b0;
    end else begin
      state    <= stateN;
      count    <= countN;
      addr     <= addrN;
      lowByte  <= lowByteN;
      csum     <= csumN;
      addrWr   <= addrWrN;
      dataWr   <= dataWrN;
      wrEn     <= wrEnN;
      loadDone <= loadDoneN;
      loadErr  <= loadErrN;
    end
  end

  always_comb begin
    stateN    = state;
    countN    = count;
    addrN     = addr;
    lowByteN  = lowByte;
    csumN     = csum;
    addrWrN   = addrWr;
    dataWrN   = dataWr;
    wrEnN     = 1'b0;
    loadDoneN = loadDone;
    loadErrN  = 1'b0;
    if (frameErr) begin
      loadErrN = 1'b1;
      stateN   = IDLE;
    end else if (byteValid) begin
      case (state)
        IDLE: begin
          if (rxByte == SYNC_BYTE) begin
            loadDoneN = 1'b0;
            stateN    = COUNT;
          end
        end
        COUNT: begin
          countN = rxByte;
          addrN  = '0;
          csumN  = '0;
          stateN = DATA_LO;
        end
        DATA_LO: begin
          lowByteN = rxByte;
          csumN    = csum ^ rxByte;
          stateN   = DATA_HI;
        end
        DATA_HI: begin
          wrEnN   = 1'b1;
          addrWrN = addr;
          dataWrN = {rxByte, lowByte};
          csumN   = csum ^ rxByte;
          addrN   = addr + 1'b1;
          // count 0 stands for 256: the 8-bit incremented address
          // only returns to 0 after the 256th word
          stateN  = ((addr + 1'b1) == count) ? CHECK : DATA_LO;
        end
        CHECK: begin
          if (rxByte == csum) begin
            loadDoneN = 1'b1;
          end else begin
            loadDoneN = 1'b0;
            loadErrN  = 1'b1;
          end
          stateN = IDLE;
        end
        default: stateN = IDLE;
      endcase
    end
  end

  assign memWr.addrWr   = addrWr;
  assign memWr.dataWr   = dataWr;
  assign memWr.wrEn     = wrEn;
  assign memWr.loadDone = loadDone;
  assign memWr.loadErr  = loadErr;

endmodule

// File: tb/tb_prog_uart_loader.sv
module tb_prog_uart_loader;
  import prog_uart_loader_pkg::*;

  localparam int unsigned BIT_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  prog_uart_loader_if pif ();

  prog_uart_loader #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .memWr (pif)
  );

  always #5 clk = ~clk;

  int unsigned nAsserts = 0;
  int unsigned nFail    = 0;

  // write/error log, sampled away from the active edge
  int unsigned nWr  = 0;
  int unsigned nErr = 0;
  logic [7:0]  wAddr [$];
  logic [15:0] wData [$];

  always @(negedge clk) begin
    if (pif.wrEn === 1'b1) begin
      wAddr.push_back(pif.addrWr);
      wData.push_back(pif.dataWr);
      nWr++;
    end
    if (pif.loadErr === 1'b1) nErr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
    rx = stopBit;
    repeat (BIT_CYC) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  int unsigned wBase, eBase;
  logic [7:0]  snapAddr;
  logic [15:0] snapData;
  logic        snapDone;

  initial begin
    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_addrWr", 32'(pif.addrWr), 32'h0);
    check("rst_dataWr", 32'(pif.dataWr), 32'h0);
    check("rst_wrEn", 32'(pif.wrEn), 32'h0);
    check("rst_loadDone", 32'(pif.loadDone), 32'h0);
    check("rst_loadErr", 32'(pif.loadErr), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // good two-word frame
    wBase = nWr; eBase = nErr;
    sendByte(8'hA5, 1'b1); sendByte(8'h02, 1'b1);
    sendByte(8'h34, 1'b1); sendByte(8'h12, 1'b1);
    sendByte(8'hCD, 1'b1); sendByte(8'hAB, 1'b1);
    sendByte(8'h40, 1'b1);
    check("good_nwr", nWr - wBase, 32'd2);
    check("good_w0_addr", 32'(wAddr[wBase]), 32'h00);
    check("good_w0_data", 32'(wData[wBase]), 32'h1234);
    check("good_w1_addr", 32'(wAddr[wBase+1]), 32'h01);
    check("good_w1_data", 32'(wData[wBase+1]), 32'hABCD);
    check("good_done", 32'(pif.loadDone), 32'h1);
    check("good_nerr", nErr - eBase, 32'd0);
    check("good_hold_addr", 32'(pif.addrWr), 32'h01);
    check("good_hold_data", 32'(pif.dataWr), 32'hABCD);

    // same frame, bad checksum
    wBase = nWr; eBase = nErr;
    sendByte(8'hA5, 1'b1); sendByte(8'h02, 1'b1);
    sendByte(8'h34, 1'b1); sendByte(8'h12, 1'b1);
    sendByte(8'hCD, 1'b1); sendByte(8'hAB, 1'b1);
    sendByte(8'h41, 1'b1);
    check("bad_nwr", nWr - wBase, 32'd2);
    check("bad_w1_data", 32'(wData[wBase+1]), 32'hABCD);
    check("bad_nerr", nErr - eBase, 32'd1);
    check("bad_done", 32'(pif.loadDone), 32'h0);

    // leading junk byte, one word
    wBase = nWr; eBase = nErr;
    sendByte(8'h5A, 1'b1); sendByte(8'hA5, 1'b1);
    sendByte(8'h01, 1'b1); sendByte(8'hFF, 1'b1);
    sendByte(8'h00, 1'b1); sendByte(8'hFF, 1'b1);
    check("junk_nwr", nWr - wBase, 32'd1);
    check("junk_w0_addr", 32'(wAddr[wBase]), 32'h00);
    check("junk_w0_data", 32'(wData[wBase]), 32'h00FF);
    check("junk_done", 32'(pif.loadDone), 32'h1);
    check("junk_nerr", nErr - eBase, 32'd0);

    // framing error on the high byte
    wBase = nWr; eBase = nErr;
    sendByte(8'hA5, 1'b1); sendByte(8'h01, 1'b1);
    sendByte(8'h34, 1'b1); sendByte(8'h12, 1'b0);
    check("ferr_nwr", nWr - wBase, 32'd0);
    check("ferr_nerr", nErr - eBase, 32'd1);
    check("ferr_state", 32'(dut.state), 32'(IDLE));
    check("ferr_done", 32'(pif.loadDone), 32'h0);

    // short low glitch
    wBase = nWr; eBase = nErr;
    snapAddr = pif.addrWr; snapData = pif.dataWr; snapDone = pif.loadDone;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_nwr", nWr - wBase, 32'd0);
    check("glitch_nerr", nErr - eBase, 32'd0);
    check("glitch_addr", 32'(pif.addrWr), 32'(snapAddr));
    check("glitch_data", 32'(pif.dataWr), 32'(snapData));
    check("glitch_done", 32'(pif.loadDone), 32'(snapDone));

    // reset between low and high byte, then fresh frame
    wBase = nWr; eBase = nErr;
    sendByte(8'hA5, 1'b1); sendByte(8'h01, 1'b1);
    sendByte(8'h11, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_addrWr", 32'(pif.addrWr), 32'h0);
    check("mrst_dataWr", 32'(pif.dataWr), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_nwr_pre", nWr - wBase, 32'd0);
    sendByte(8'hA5, 1'b1); sendByte(8'h01, 1'b1);
    sendByte(8'h11, 1'b1); sendByte(8'h22, 1'b1);
    sendByte(8'h33, 1'b1);
    check("mrst_nwr", nWr - wBase, 32'd1);
    check("mrst_w0_addr", 32'(wAddr[wBase]), 32'h00);
    check("mrst_w0_data", 32'(wData[wBase]), 32'h2211);
    check("mrst_done", 32'(pif.loadDone), 32'h1);
    check("mrst_nerr", nErr - eBase, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
